// File: rtl/lab1_fp_decoder.sv
// rtl/lab1_fp_decoder.sv - sequential 8-bit float to 12-bit two's-complement decoder
module lab1_fp_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        S,
    input  logic [2:0]  E,
    input  logic [3:0]  F,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] D
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] SIGN  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state;
    logic [10:0] mag;
    logic [2:0]  cnt;
    logic        sgn;

    // Accept only while idle; depends on state alone so no input-to-output path exists.
    assign in_ready = (state == IDLE);

    // Decode FSM: latch the word, shift one bit per cycle, apply sign, hold until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mag       <= 11'd0;
            cnt       <= 3'd0;
            sgn       <= 1'b0;
            D         <= 12'd0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag   <= {7'b0, F};
                        cnt   <= E;
                        sgn   <= S;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != 3'd0) begin
                        mag <= mag << 1;
                        cnt <= cnt - 3'd1;
                    end else begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    // Negating a zero magnitude yields zero, so there is no -0.
                    D         <= sgn ? (~{1'b0, mag} + 12'd1) : {1'b0, mag};
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lab1_fp_decoder.sv
// tb/tb_lab1_fp_decoder.sv - directed self-checking bench for lab1_fp_decoder
module tb_lab1_fp_decoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        S;
    logic [2:0]  E;
    logic [3:0]  F;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] D;

    int checks;
    int fails;

    lab1_fp_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .E         (E),
        .F         (F),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one word, verify latency and result, optionally stall, then complete handshake.
    task automatic run_word(input string tag, input logic s, input logic [2:0] e,
                            input logic [3:0] f, input logic [11:0] exp_d, input int hold);
        int n;
        logic [11:0] d_seen;
        @(negedge clk);
        check_eq({tag, " in_ready_before"}, in_ready, 1);
        S = s; E = e; F = f; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Inputs after the accept edge must not matter.
        S = ~s; E = ~e; F = ~f;
        check_eq({tag, " in_ready_busy"}, in_ready, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, " latency"}, n, 32'(e) + 2);
        check_eq({tag, " D"}, D, exp_d);
        d_seen = D;
        for (int i = 0; i < hold; i++) begin
            in_valid = ~in_valid;
            S = $urandom_range(0, 1);
            E = 3'($urandom_range(0, 7));
            F = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
            check_eq({tag, " hold_D"}, D, d_seen);
            check_eq({tag, " hold_out_valid"}, out_valid, 1);
            check_eq({tag, " hold_in_ready"}, in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, " out_valid_clear"}, out_valid, 0);
        check_eq({tag, " in_ready_after"}, in_ready, 1);
        check_eq({tag, " D_kept_idle"}, D, exp_d);
    endtask

    initial begin
        checks = 0;
        fails = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        S = 1'b0; E = 3'd0; F = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset in_ready", in_ready, 1);
        check_eq("reset out_valid", out_valid, 0);
        check_eq("reset D", D, 12'h000);
        @(negedge clk);
        rst = 1'b0;

        run_word("zero_e0",   1'b0, 3'd0, 4'd0,  12'h000, 0);
        run_word("max_pos",   1'b0, 3'd7, 4'd15, 12'h780, 0);
        run_word("neg72",     1'b1, 3'd3, 4'd9,  12'hFB8, 0);
        run_word("max_neg",   1'b1, 3'd7, 4'd15, 12'h880, 0);
        run_word("neg_zero",  1'b1, 3'd5, 4'd0,  12'h000, 0);
        run_word("pos3_e4",   1'b0, 3'd4, 4'd3,  12'h030, 0);
        run_word("backpress", 1'b0, 3'd2, 4'd5,  12'h014, 5);

        // Abort a conversion mid-shift with an asynchronous reset.
        @(negedge clk);
        S = 1'b0; E = 3'd6; F = 4'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("abort D_before", D, 12'h014);
        rst = 1'b1;
        #1;
        check_eq("abort out_valid", out_valid, 0);
        check_eq("abort D", D, 12'h000);
        check_eq("abort in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check_eq("abort no_result", out_valid, 0);
        end
        run_word("after_abort", 1'b0, 3'd1, 4'd1, 12'h002, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
